// File: rtl/ddr3_pg_arbiter.sv
// N-requester arbiter in front of the single DDR3 page-transfer engine.
// Fixed-priority or round-robin grant, enable masking, release holdoff, per-requester counters.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | no grant held; picks a winner from req_pg_req & req_en
//   ST_ACTIVE  | grant latched, ddr3_pg_req high, DPRAM routed to winner
//   ST_HOLDOFF | acked; waiting for the winner to drop its request level
module ddr3_pg_arbiter #(
  parameter int N_REQ        = 3,
  parameter int P_ADDR_WIDTH = 28,
  parameter int P_DATA_WIDTH = 128,
  parameter int P_ARB_MODE   = 1,
  parameter int P_CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_en,
  input  logic [N_REQ-1:0]              req_pg_req,
  input  logic [N_REQ-1:0]              req_pg_optype,
  input  logic [N_REQ*P_ADDR_WIDTH-1:0] req_pg_addr,
  output logic [N_REQ-1:0]              req_pg_ack,
  input  logic [N_REQ*P_DATA_WIDTH-1:0] req_dpram_dout,
  output logic [N_REQ-1:0]              req_dpram_wren,
  output logic                          ddr3_pg_req,
  output logic                          ddr3_pg_optype,
  output logic [P_ADDR_WIDTH-1:0]       ddr3_pg_req_addr,
  input  logic                          ddr3_pg_ack,
  output logic [P_DATA_WIDTH-1:0]       ddr3_dpram_dout,
  input  logic                          ddr3_dpram_wren,
  output logic [2:0]                    grant_idx,
  output logic                          busy,
  input  logic                          cnt_clr,
  output logic [N_REQ*P_CNT_WIDTH-1:0]  xfer_cnt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACTIVE  = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [2:0]              grant_q, grant_d;
  logic [2:0]              rr_ptr_q, rr_ptr_d;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                    optype_q, optype_d;
  logic [N_REQ-1:0]        ack_q, ack_d;
  logic [P_CNT_WIDTH-1:0]  cnt_q [N_REQ];
  logic [P_CNT_WIDTH-1:0]  cnt_d [N_REQ];

  logic [N_REQ-1:0] elig;
  logic [2:0]       start;
  logic [3:0]       cand;
  logic [2:0]       win;
  logic             win_vld;

  assign elig = req_pg_req & req_en;

  // Circular search from the start point; fixed priority is the same search anchored at 0.
  always_comb begin
    start   = (P_ARB_MODE == 1) ? rr_ptr_q : 3'd0;
    cand    = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, start} + 4'(k);
      if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
      if (!win_vld && elig[cand[2:0]]) begin
        win     = cand[2:0];
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    optype_d = optype_q;
    ack_d    = '0;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          grant_d  = win;
          addr_d   = req_pg_addr[win*P_ADDR_WIDTH +: P_ADDR_WIDTH];
          optype_d = req_pg_optype[win];
          state_d  = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (ddr3_pg_ack) begin
          ack_d[grant_q] = 1'b1;
          rr_ptr_d       = (grant_q == 3'(N_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
          if (cnt_q[grant_q] != '1) cnt_d[grant_q] = cnt_q[grant_q] + 1'b1;
          state_d        = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (!req_pg_req[grant_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (cnt_clr) begin
      for (int i = 0; i < N_REQ; i++) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      optype_q <= 1'b0;
      ack_q    <= '0;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      optype_q <= optype_d;
      ack_q    <= ack_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ddr3_pg_req      = (state_q == ST_ACTIVE);
  assign ddr3_pg_optype   = optype_q;
  assign ddr3_pg_req_addr = addr_q;
  assign grant_idx        = grant_q;
  assign busy             = (state_q != ST_IDLE);
  assign req_pg_ack       = ack_q;
  assign ddr3_dpram_dout  = req_dpram_dout[grant_q*P_DATA_WIDTH +: P_DATA_WIDTH];

  // Engine write strobes outside a live transfer are dropped.
  always_comb begin
    req_dpram_wren = '0;
    if (state_q == ST_ACTIVE && ddr3_dpram_wren) req_dpram_wren[grant_q] = 1'b1;
  end

  always_comb begin
    xfer_cnt = '0;
    for (int i = 0; i < N_REQ; i++) xfer_cnt[i*P_CNT_WIDTH +: P_CNT_WIDTH] = cnt_q[i];
  end

endmodule

// File: tb/tb_ddr3_pg_arbiter.sv
// Scoreboard bench for ddr3_pg_arbiter: round-robin instance and fixed-priority instance,
// the idle one held in reset; expected grants/acks come from a transaction-level model.
module tb_ddr3_pg_arbiter;
  localparam int N  = 3;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sel_fp;
  logic [N-1:0]    req_en, req_pg_req, req_pg_optype;
  logic [N*AW-1:0] req_pg_addr;
  logic [N*DW-1:0] req_dpram_dout;
  logic            ddr3_pg_ack, ddr3_dpram_wren, cnt_clr;

  logic            rst_rr, rst_fp;
  logic [N-1:0]    rr_ack, fp_ack, rr_wren, fp_wren;
  logic            rr_pg_req, fp_pg_req, rr_op, fp_op, rr_busy, fp_busy;
  logic [AW-1:0]   rr_addr, fp_addr;
  logic [DW-1:0]   rr_dout, fp_dout;
  logic [2:0]      rr_grant, fp_grant;
  logic [N*CW-1:0] rr_xfer, fp_xfer;

  assign rst_rr = rst | sel_fp;
  assign rst_fp = rst | ~sel_fp;

  ddr3_pg_arbiter #(.N_REQ(N), .P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_ARB_MODE(1), .P_CNT_WIDTH(CW)) u_rr (
    .clk(clk), .rst(rst_rr), .req_en(req_en), .req_pg_req(req_pg_req), .req_pg_optype(req_pg_optype),
    .req_pg_addr(req_pg_addr), .req_pg_ack(rr_ack), .req_dpram_dout(req_dpram_dout), .req_dpram_wren(rr_wren),
    .ddr3_pg_req(rr_pg_req), .ddr3_pg_optype(rr_op), .ddr3_pg_req_addr(rr_addr), .ddr3_pg_ack(ddr3_pg_ack),
    .ddr3_dpram_dout(rr_dout), .ddr3_dpram_wren(ddr3_dpram_wren), .grant_idx(rr_grant), .busy(rr_busy),
    .cnt_clr(cnt_clr), .xfer_cnt(rr_xfer));

  ddr3_pg_arbiter #(.N_REQ(N), .P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_ARB_MODE(0), .P_CNT_WIDTH(CW)) u_fp (
    .clk(clk), .rst(rst_fp), .req_en(req_en), .req_pg_req(req_pg_req), .req_pg_optype(req_pg_optype),
    .req_pg_addr(req_pg_addr), .req_pg_ack(fp_ack), .req_dpram_dout(req_dpram_dout), .req_dpram_wren(fp_wren),
    .ddr3_pg_req(fp_pg_req), .ddr3_pg_optype(fp_op), .ddr3_pg_req_addr(fp_addr), .ddr3_pg_ack(ddr3_pg_ack),
    .ddr3_dpram_dout(fp_dout), .ddr3_dpram_wren(ddr3_dpram_wren), .grant_idx(fp_grant), .busy(fp_busy),
    .cnt_clr(cnt_clr), .xfer_cnt(fp_xfer));

  logic [N-1:0]    m_ack, m_wren;
  logic            m_pg_req, m_op, m_busy;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_dout;
  logic [2:0]      m_grant;
  logic [N*CW-1:0] m_xfer;
  assign m_ack    = sel_fp ? fp_ack    : rr_ack;
  assign m_wren   = sel_fp ? fp_wren   : rr_wren;
  assign m_pg_req = sel_fp ? fp_pg_req : rr_pg_req;
  assign m_op     = sel_fp ? fp_op     : rr_op;
  assign m_busy   = sel_fp ? fp_busy   : rr_busy;
  assign m_addr   = sel_fp ? fp_addr   : rr_addr;
  assign m_dout   = sel_fp ? fp_dout   : rr_dout;
  assign m_grant  = sel_fp ? fp_grant  : rr_grant;
  assign m_xfer   = sel_fp ? fp_xfer   : rr_xfer;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int idx; logic [AW-1:0] addr; logic op; longint cyc; } gexp_t;
  typedef struct { logic [N-1:0] mask; longint cyc; } aexp_t;
  gexp_t gq[$];
  aexp_t aq[$];

  int checks = 0, failures = 0;
  int ptr;
  int cnt_m [N];
  int exp_w;
  logic [AW-1:0] exp_addr;
  logic          exp_op;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic abort(input string why);
    checks++;
    failures++;
    $display("FAIL %s: bound expired at cycle %0d", why, cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] elig, input int start);
    for (int k = 0; k < N; k++) begin
      if (elig[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N*CW-1:0] pack_cnt();
    logic [N*CW-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i*CW +: CW] = CW'(cnt_m[i]);
    return p;
  endfunction

  task automatic model_reset();
    ptr = 0;
    for (int i = 0; i < N; i++) cnt_m[i] = 0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      req_pg_addr[i*AW +: AW]    = AW'($urandom);
      req_dpram_dout[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
    end
    req_pg_optype = N'($urandom);
  endtask

  // Present a new request pattern while the arbiter is idle and predict the grant.
  task automatic apply(input logic [N-1:0] r, input logic [N-1:0] e);
    gexp_t g;
    req_pg_req = r;
    req_en     = e;
    exp_w      = pick(r & e, sel_fp ? 0 : ptr);
    if (exp_w >= 0) begin
      exp_addr = req_pg_addr[exp_w*AW +: AW];
      exp_op   = req_pg_optype[exp_w];
      g.idx = exp_w; g.addr = exp_addr; g.op = exp_op; g.cyc = cyc + 1;
      gq.push_back(g);
    end
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    tick();
    while (!m_pg_req && n < 10) begin
      tick();
      n++;
    end
    if (!m_pg_req) abort("grant_wait");
  endtask

  // Run one transfer for the predicted winner, through holdoff, ending idle.
  task automatic serve(input int fixed, input int hold, input bit early, input bit clr,
                       input bit do_chg, input logic [AW-1:0] chg);
    int w, d, hh;
    logic [N-1:0] ew, r;
    aexp_t a;
    w = exp_w;
    wait_grant();
    if (fixed >= 0) chk("fixed_grant_order", m_grant, fixed);
    d = $urandom_range(0, 3);
    for (int j = 0; j <= d; j++) begin
      if (j == 0 && do_chg) begin
        req_pg_addr[w*AW +: AW] = chg;
        req_pg_optype[w]        = ~req_pg_optype[w];
      end
      r = N'($urandom);
      r[w] = (j == 0 && early) ? 1'b0 : req_pg_req[w];
      req_pg_req = r;
      if (j > 0) req_en = N'($urandom);
      ddr3_dpram_wren = 1'($urandom);
      #1;
      ew = '0;
      if (ddr3_dpram_wren) ew[w] = 1'b1;
      chk("active_pg_req", m_pg_req, 1);
      chk("active_busy", m_busy, 1);
      chk("held_addr", m_addr, exp_addr);
      chk("held_optype", m_op, exp_op);
      chk("wren_route", m_wren, ew);
      chk("dout_route", m_dout, req_dpram_dout[w*DW +: DW]);
      tick();
    end
    ddr3_pg_ack     = 1'b1;
    cnt_clr         = clr;
    ddr3_dpram_wren = 1'b1;
    #1;
    ew = '0;
    ew[w] = 1'b1;
    chk("wren_route_ack", m_wren, ew);
    if (clr) begin
      for (int i = 0; i < N; i++) cnt_m[i] = 0;
    end else if (cnt_m[w] < (1 << CW) - 1) begin
      cnt_m[w]++;
    end
    ptr = (w + 1) % N;
    a.mask = '0; a.mask[w] = 1'b1; a.cyc = cyc + 1;
    aq.push_back(a);
    tick();
    ddr3_pg_ack     = 1'b0;
    cnt_clr         = 1'b0;
    ddr3_dpram_wren = 1'b1;
    #1;
    chk("pg_req_drop", m_pg_req, 0);
    chk("holdoff_busy", m_busy, 1);
    chk("wren_dropped", m_wren, 0);
    chk("xfer_cnt", m_xfer, pack_cnt());
    chk("grant_after_ack", m_grant, w);
    hh = early ? 0 : hold;
    for (int h = 0; h < hh; h++) begin
      ddr3_pg_ack     = 1'($urandom);
      ddr3_dpram_wren = 1'($urandom);
      tick();
      chk("holdoff_stay", m_busy, 1);
      chk("holdoff_no_req", m_pg_req, 0);
      chk("holdoff_wren", m_wren, 0);
    end
    req_pg_req      = '0;
    ddr3_pg_ack     = 1'($urandom);
    ddr3_dpram_wren = 1'b0;
    tick();
    ddr3_pg_ack = 1'b0;
    chk("idle_after_release", m_busy, 0);
    chk("grant_kept_idle", m_grant, w);
    chk("xfer_cnt_idle", m_xfer, pack_cnt());
  endtask

  task automatic rand_round();
    logic [N-1:0] r, e;
    r = N'($urandom);
    e = N'($urandom | $urandom);
    rand_data();
    apply(r, e);
    if (exp_w < 0) begin
      tick();
      chk("no_eligible_idle", m_busy, 0);
      tick();
      chk("no_eligible_idle", m_busy, 0);
    end else begin
      serve(-1, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            1'($urandom), AW'($urandom));
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT starts a request or pulses an ack.
  logic prev_req = 1'b0;
  initial begin
    gexp_t g;
    aexp_t a;
    forever begin
      @(negedge clk);
      if (m_pg_req && !prev_req) begin
        chk("grant_expected", gq.size() != 0, 1);
        if (gq.size() != 0) begin
          g = gq.pop_front();
          chk("grant_idx", m_grant, g.idx);
          chk("grant_addr", m_addr, g.addr);
          chk("grant_optype", m_op, g.op);
          chk("grant_latency", cyc, g.cyc);
        end
      end
      prev_req = m_pg_req;
      if (m_ack != '0) begin
        chk("ack_expected", aq.size() != 0, 1);
        if (aq.size() != 0) begin
          a = aq.pop_front();
          chk("ack_mask", m_ack, a.mask);
          chk("ack_cycle", cyc, a.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    abort("watchdog");
  end

  initial begin
    rst = 1'b1; sel_fp = 1'b0;
    req_en = '0; req_pg_req = '0; req_pg_optype = '0; req_pg_addr = '0; req_dpram_dout = '0;
    ddr3_pg_ack = 1'b0; ddr3_dpram_wren = 1'b0; cnt_clr = 1'b0;
    exp_w = -1;
    model_reset();
    repeat (3) tick();
    ddr3_pg_ack = 1'b1; ddr3_dpram_wren = 1'b1;
    #1;
    chk("rst_pg_req", m_pg_req, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_optype", m_op, 0);
    chk("rst_ack", m_ack, 0);
    chk("rst_grant", m_grant, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_xfer", m_xfer, 0);
    chk("rst_wren", m_wren, 0);
    ddr3_pg_ack = 1'b0; ddr3_dpram_wren = 1'b0;
    rst = 1'b0;
    tick();

    // Round robin, everyone re-requesting: 0,1,2,0,1,2.
    rand_data();
    apply(3'b111, 3'b111);
    for (int i = 0; i < 6; i++) begin
      serve(i % 3, $urandom_range(0, 2), 1'b0, 1'b0, 1'b0, '0);
      rand_data();
      if (i < 5) apply(3'b111, 3'b111);
    end
    chk("xfer_cnt_222", m_xfer, 12'h222);

    // Requester 1 masked.
    apply(3'b111, 3'b101);
    for (int i = 0; i < 4; i++) begin
      serve((i % 2 == 0) ? 0 : 2, $urandom_range(0, 2), 1'b0, 1'b0, 1'b0, '0);
      rand_data();
      if (i < 3) apply(3'b111, 3'b101);
    end

    // Address change mid-transfer is ignored; requester holds req 3 cycles after ack.
    req_pg_addr[0 +: AW] = 28'h0000100;
    req_pg_optype[0]     = 1'b1;
    apply(3'b001, 3'b111);
    serve(0, 3, 1'b0, 1'b0, 1'b1, 28'h0FFFFFF);

    // Counter saturation, then clear colliding with an increment.
    for (int i = 0; i < 17; i++) begin
      rand_data();
      apply(3'b100, 3'b111);
      serve(2, $urandom_range(0, 1), 1'b0, 1'b0, 1'b0, '0);
    end
    chk("xfer_sat", m_xfer[2*CW +: CW], 4'hF);
    rand_data();
    apply(3'b100, 3'b111);
    serve(2, 0, 1'b0, 1'b1, 1'b0, '0);
    chk("clr_beats_inc", m_xfer, 0);

    for (int i = 0; i < 40; i++) rand_round();

    // Reset in the middle of a transfer: no ack, everything back to zero.
    rand_data();
    apply(3'b010, 3'b111);
    wait_grant();
    rst = 1'b1;
    ddr3_pg_ack = 1'b1;
    tick();
    ddr3_pg_ack = 1'b0;
    req_pg_req  = '0;
    model_reset();
    chk("midrst_pg_req", m_pg_req, 0);
    chk("midrst_addr", m_addr, 0);
    chk("midrst_optype", m_op, 0);
    chk("midrst_ack", m_ack, 0);
    chk("midrst_grant", m_grant, 0);
    chk("midrst_busy", m_busy, 0);
    chk("midrst_xfer", m_xfer, 0);
    rst = 1'b0;
    tick();
    rand_data();
    apply(3'b111, 3'b111);
    serve(0, 1, 1'b0, 1'b0, 1'b0, '0);

    // Fixed priority instance.
    rst = 1'b1;
    sel_fp = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    tick();
    chk("fp_rst_busy", m_busy, 0);
    chk("fp_rst_xfer", m_xfer, 0);
    for (int i = 0; i < 3; i++) begin
      rand_data();
      apply(3'b110, 3'b111);
      serve(1, $urandom_range(0, 2), 1'b0, 1'b0, 1'b0, '0);
    end
    rand_data();
    apply(3'b100, 3'b111);
    serve(2, 0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++) rand_round();

    repeat (3) tick();
    chk("grant_queue_drained", gq.size(), 0);
    chk("ack_queue_drained", aq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ddr3_pg_arbiter.md
Name: ddr3_pg_arbiter

Overview:
- N-requester arbiter for DDR3 page transfers. It is the parametrised successor to the fixed two-input page-transfer mux (hit buffer and xdom).
- Runs in the DDR3 UI clock domain, between page-transfer requesters (hit buffer controller, xdom, future readout engines) and the single DDR3 DPRAM transfer engine.
- Adds a selectable fixed-priority or round-robin policy, per-requester enable masking, a requester-release holdoff, and per-requester transfer counters.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- P_ADDR_WIDTH, 28, page request address width.
- P_DATA_WIDTH, 128, DPRAM data width.
- P_ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round robin.
- P_CNT_WIDTH, 16, width of each transfer counter.

Ports:
- clk  in  1  DDR3 UI clock.
- rst  in  1  synchronous, active-high reset.
- req_en  in  N_REQ  per-requester enable; a disabled requester is never granted.
- req_pg_req  in  N_REQ  level page request; held high until acked.
- req_pg_optype  in  N_REQ  per-requester optype (0 read, 1 write).
- req_pg_addr  in  N_REQ*P_ADDR_WIDTH  packed request addresses; requester i occupies slice [i*W +: W].
- req_pg_ack  out  N_REQ  one-cycle completion pulse to the granted requester.
- req_dpram_dout  in  N_REQ*P_DATA_WIDTH  packed DPRAM read data from each requester.
- req_dpram_wren  out  N_REQ  DPRAM write enable, routed to the granted requester only.
- ddr3_pg_req  out  1  request to the transfer engine.
- ddr3_pg_optype  out  1  optype of the granted request.
- ddr3_pg_req_addr  out  P_ADDR_WIDTH  address of the granted request.
- ddr3_pg_ack  in  1  one-cycle completion pulse from the transfer engine.
- ddr3_dpram_dout  out  P_DATA_WIDTH  granted requester's DPRAM data.
- ddr3_dpram_wren  in  1  DPRAM write enable from the transfer engine.
- grant_idx  out  3  index of the current or last grant.
- busy  out  1  high in any state other than IDLE.
- cnt_clr  in  1  synchronous clear of all transfer counters.
- xfer_cnt  out  N_REQ*P_CNT_WIDTH  completed transfers per requester, saturating.

Behaviour:
- Reset: state IDLE; ddr3_pg_req, ddr3_pg_optype, ddr3_pg_req_addr, req_pg_ack, grant_idx, busy, xfer_cnt all 0; round-robin pointer = 0. Reset mid-transfer abandons the grant; no ack is issued.
- Eligible set: req_pg_req & req_en.
- IDLE: if the eligible set is non-zero, select a winner and latch grant_idx, addr and optype.
  - Mode 0: lowest-index eligible requester wins.
  - Mode 1: search starts at (last_grant+1) mod N_REQ and wraps.
  - Next cycle: state ACTIVE, ddr3_pg_req = 1. Latency from request to ddr3_pg_req is 1 cycle.
- ACTIVE:
  - ddr3_pg_req held high; addr and optype held stable from the latched values, ignoring later input changes.
  - On ddr3_pg_ack: next cycle ddr3_pg_req = 0, req_pg_ack[grant_idx] = 1 for exactly one cycle, xfer_cnt[grant_idx] += 1 (saturates at all-ones), last_grant = grant_idx, state HOLDOFF.
  - A requester dropping req or req_en during ACTIVE is ignored; the transfer completes and is still acked.
- HOLDOFF: stay until req_pg_req[grant_idx] == 0, then go to IDLE next cycle. This prevents re-granting a request whose level has not yet fallen. No new grant is issued in HOLDOFF.
- DPRAM routing (combinational from the grant register):
  - ddr3_dpram_dout = slice grant_idx of req_dpram_dout.
  - req_dpram_wren[i] = ddr3_dpram_wren & (i == grant_idx) & (state == ACTIVE); all zero otherwise.
  - ddr3_dpram_wren outside ACTIVE is dropped.
- ddr3_pg_ack outside ACTIVE is ignored.
- cnt_clr has priority over an increment in the same cycle; the counter reads 0 afterwards.
- grant_idx keeps the last grant while in IDLE.

Test Plan:
- Mode 1, N_REQ=3: requesters 0, 1 and 2 request simultaneously and re-request after each ack -> grant order 0,1,2,0,1,2; each ack is a 1-cycle pulse the cycle after ddr3_pg_ack; xfer_cnt = 2,2,2.
- Mode 0: req 1 and req 2 are held continuously -> only 1 is served while it keeps requesting; 2 is served only once req 1 drops.
- req_en = 3'b101 with all requesting -> requester 1 is never granted and req_pg_ack[1] stays 0.
- Requester 0 (addr 0x0000100, optype 1) is granted, then changes addr to 0x0FFFFFF mid-transfer -> ddr3_pg_req_addr stays 0x0000100 until ack; ddr3_dpram_wren pulses appear only on req_dpram_wren[0].
- Requester holds req for 3 cycles after ack -> arbiter remains in HOLDOFF, busy = 1, no second grant; IDLE is reached 1 cycle after req falls.
- rst asserted in ACTIVE -> next cycle all outputs are 0 and no ack occurs; with P_CNT_WIDTH=4 and 17 transfers, xfer_cnt = 0xF; cnt_clr together with an ack -> counter 0.
